// File: rtl/serializer_arb_pkg.sv
// Shared types and width helpers for the serializer frame arbiter.
package serializer_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    function automatic int word_cnt_width(input int n_samples);
        return $clog2(n_samples) + 1;
    endfunction

    function automatic int chan_id_width(input int n_ch);
        return $clog2(n_ch);
    endfunction

    localparam int DEF_WORD_CNT_W = word_cnt_width(8);
    localparam int DEF_CHAN_ID_W  = chan_id_width(4);

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational grant picker: round-robin after last_grant by default,
// lowest-index fixed priority when SERIALIZER_ARB_FIXED_PRIO_EN is defined.
module rr_priority_picker
    import serializer_arb_pkg::*;
#(
    parameter int N_CH = 4
) (
    input  logic [N_CH-1:0]                 req,
    input  logic [chan_id_width(N_CH)-1:0]  last_grant,
    output logic [N_CH-1:0]                 grant,
    output logic [chan_id_width(N_CH)-1:0]  grant_idx,
    output logic                            req_any
);
    localparam int CHW = chan_id_width(N_CH);

    logic found;
    int   idx;

    assign req_any = |req;

`ifdef SERIALIZER_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < N_CH; i++) begin
            if (!found && req[i]) begin
                found     = 1'b1;
                idx       = i;
                grant[i]  = 1'b1;
                grant_idx = CHW'(i);
            end
        end
    end
`else
    // Search starts one past the previous winner and wraps around.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= N_CH) idx = idx - N_CH;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = CHW'(idx);
            end
        end
    end
`endif

endmodule

// File: rtl/serializer_frame_arbiter.sv
// Shares one serializer among N_CH frame producers; holds the grant until the
// snooped send handshake has emitted N_SAMPLES words. Option: SERIALIZER_ARB_FIXED_PRIO_EN.
//   state | meaning
//   IDLE  | waiting for any req_val; grants and latches a frame
//   ISSUE | latched frame offered on ser_msg/ser_val until ser_rdy
//   DRAIN | counting serializer send fires until the frame is out
module serializer_frame_arbiter
    import serializer_arb_pkg::*;
#(
    parameter int BIT_WIDTH = 32,
    parameter int N_SAMPLES = 8,
    parameter int N_CH      = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [N_CH*N_SAMPLES*BIT_WIDTH-1:0] req_msg,
    input  logic [N_CH-1:0]                     req_val,
    output logic [N_CH-1:0]                     req_rdy,
    output logic [N_SAMPLES*BIT_WIDTH-1:0]      ser_msg,
    output logic                                ser_val,
    input  logic                                ser_rdy,
    input  logic                                mon_val,
    input  logic                                mon_rdy,
    output logic [chan_id_width(N_CH)-1:0]      cur_chan,
    output logic                                cur_chan_val
);
    localparam int CHW  = chan_id_width(N_CH);
    localparam int CNTW = word_cnt_width(N_SAMPLES);
    localparam int FW   = N_SAMPLES * BIT_WIDTH;

    arb_state_t      state;
    logic [CHW-1:0]  last_grant;
    logic [CHW-1:0]  grant_idx;
    logic [CNTW-1:0] word_cnt;
    logic [FW-1:0]   frame_buf;
    logic [FW-1:0]   sel_frame;
    logic [N_CH-1:0] grant;
    logic            req_any;
    logic            accept;
    logic            fire;

    rr_priority_picker #(.N_CH(N_CH)) u_picker (
        .req        (req_val),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .req_any    (req_any)
    );

    always_comb begin
        sel_frame = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (grant_idx == CHW'(c)) sel_frame = req_msg[c*FW +: FW];
        end
    end

    // Gated by reset so no requester sees an accept that the reset discards.
    assign accept       = (state == IDLE) && req_any && !reset;
    assign req_rdy      = accept ? grant : '0;
    assign fire         = mon_val && mon_rdy;
    assign ser_val      = (state == ISSUE);
    assign ser_msg      = frame_buf;
    assign cur_chan_val = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= CHW'(N_CH-1);
            word_cnt   <= '0;
            frame_buf  <= '0;
            cur_chan   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        frame_buf <= sel_frame;
                        cur_chan  <= grant_idx;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (ser_rdy) begin
                        word_cnt <= '0;
                        state    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fire) begin
                        word_cnt <= word_cnt + 1'b1;
                        if (word_cnt == CNTW'(N_SAMPLES-1)) begin
                            state <= IDLE;
`ifndef SERIALIZER_ARB_FIXED_PRIO_EN
                            last_grant <= cur_chan;
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serializer_frame_arbiter.sv
// Self-checking bench for serializer_frame_arbiter: vector table, hand sequences
// and randomized traffic against a frame-level reference model.
module tb_serializer_frame_arbiter;
    localparam int NCH = 4;
    localparam int NS  = 8;
    localparam int BW  = 32;
    localparam int FW  = NS * BW;

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH*FW-1:0] req_msg;
    logic [NCH-1:0]    req_val;
    logic [NCH-1:0]    req_rdy;
    logic [FW-1:0]     ser_msg;
    logic              ser_val;
    logic              ser_rdy;
    logic              mon_val;
    logic              mon_rdy;
    logic [1:0]        cur_chan;
    logic              cur_chan_val;

    always #5 clk = ~clk;

    serializer_frame_arbiter #(.BIT_WIDTH(BW), .N_SAMPLES(NS), .N_CH(NCH)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_msg      (req_msg),
        .req_val      (req_val),
        .req_rdy      (req_rdy),
        .ser_msg      (ser_msg),
        .ser_val      (ser_val),
        .ser_rdy      (ser_rdy),
        .mon_val      (mon_val),
        .mon_rdy      (mon_rdy),
        .cur_chan     (cur_chan),
        .cur_chan_val (cur_chan_val)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: channel owning the serializer (-1 = free), whether the
    // frame has been handed off, and how many words are still to be sent.
    int            m_chan;
    bit            m_handed;
    int            m_left;
    int            m_last;
    logic [FW-1:0] m_frame;

    typedef struct {
        logic           rst;
        logic [NCH-1:0] rv;
        logic           sr;
        logic           mv;
        logic           mr;
        logic [NCH-1:0] e_rdy;
        logic           e_sv;
        logic           e_cv;
        logic [1:0]     e_ch;
    } vec_t;

    vec_t tbl[17];

    function automatic int pick(input logic [NCH-1:0] r, input int last);
`ifdef SERIALIZER_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NCH; i++) if (r[i]) return i;
`else
        for (int k = 1; k <= NCH; k++) if (r[(last + k) % NCH]) return (last + k) % NCH;
`endif
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [NCH-1:0] v);
        for (int i = 0; i < NCH; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    endtask

    task automatic sample_and_check();
        logic [NCH-1:0] e_rdy;
        int g;
        @(negedge clk);
        e_rdy = '0;
        if (m_chan < 0 && !reset && req_val != '0) begin
            g = pick(req_val, m_last);
            e_rdy[g] = 1'b1;
        end
        chk("model_req_rdy", FW'(req_rdy), FW'(e_rdy));
        chk("model_ser_val", FW'(ser_val), FW'(m_chan >= 0 && !m_handed));
        chk("model_cur_chan_val", FW'(cur_chan_val), FW'(m_chan >= 0));
        if (m_chan >= 0 && !m_handed) chk("model_ser_msg", ser_msg, m_frame);
        if (m_chan >= 0) chk("model_cur_chan", FW'(cur_chan), FW'(m_chan));
    endtask

    task automatic advance();
        int g;
        @(posedge clk);
        if (reset) begin
            m_chan = -1; m_handed = 1'b0; m_left = 0; m_last = NCH - 1;
        end else if (m_chan < 0) begin
            if (req_val != '0) begin
                g = pick(req_val, m_last);
                m_chan = g;
                m_handed = 1'b0;
                for (int i = 0; i < NS; i++) m_frame[i*BW +: BW] = req_msg[(g*NS + i)*BW +: BW];
            end
        end else if (!m_handed) begin
            if (ser_rdy) begin
                m_handed = 1'b1;
                m_left = NS;
            end
        end else if (mon_val && mon_rdy) begin
            m_left--;
            if (m_left == 0) begin
                m_last = m_chan;
                m_chan = -1;
            end
        end
        #1;
        cyc++;
    endtask

    task automatic step();
        sample_and_check();
        advance();
    endtask

    task automatic drive(input logic [NCH-1:0] rv, input logic sr, input logic mv, input logic mr);
        req_val = rv; ser_rdy = sr; mon_val = mv; mon_rdy = mr;
    endtask

    task automatic fill_frames(input int base);
        for (int c = 0; c < NCH; c++)
            for (int i = 0; i < NS; i++)
                req_msg[(c*NS + i)*BW +: BW] = BW'(base + c*'h100 + 'h10 + i);
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        drive('0, 1'b0, 1'b0, 1'b0);
        advance();
        advance();
        reset = 1'b0;
    endtask

    int            got_idx[$];
    int            got_cyc[$];
    logic [FW-1:0] exp_frame;

    initial begin
        req_msg = '0;
        fill_frames(0);
        reset_dut();

        // rst rv sr mv mr | e_rdy e_sv e_cv e_ch
        tbl[0]  = '{1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};
        tbl[1]  = '{1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 2'd0};
        tbl[2]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd0};
        tbl[3]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd0};
        tbl[4]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd0};
        tbl[5]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0};
        tbl[6]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0};
        tbl[7]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0};
        tbl[8]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0};
        tbl[9]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0};
        tbl[10] = '{1'b0, 4'b1111, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0};
        tbl[11] = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0};
        tbl[12] = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0};
        tbl[13] = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0};
        tbl[14] = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0};
        tbl[15] = '{1'b0, 4'b1010, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 2'd0};
        tbl[16] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd1};

        for (int v = 0; v < 17; v++) begin
            reset = tbl[v].rst;
            drive(tbl[v].rv, tbl[v].sr, tbl[v].mv, tbl[v].mr);
            sample_and_check();
            chk($sformatf("tbl%0d_req_rdy", v), FW'(req_rdy), FW'(tbl[v].e_rdy));
            chk($sformatf("tbl%0d_ser_val", v), FW'(ser_val), FW'(tbl[v].e_sv));
            chk($sformatf("tbl%0d_cur_chan_val", v), FW'(cur_chan_val), FW'(tbl[v].e_cv));
            if (tbl[v].e_cv) chk($sformatf("tbl%0d_cur_chan", v), FW'(cur_chan), FW'(tbl[v].e_ch));
            if (v == 2) begin
                for (int i = 0; i < NS; i++) exp_frame[i*BW +: BW] = BW'('h10 + i);
                chk("tbl_first_frame", ser_msg, exp_frame);
            end
            advance();
        end

        // ser_rdy held low for 5 cycles while producers change their data.
        reset_dut();
        fill_frames('h5000);
        for (int i = 0; i < NS; i++) exp_frame[i*BW +: BW] = BW'('h5000 + 'h100 + 'h10 + i);
        drive(4'b0010, 1'b0, 1'b0, 1'b0);
        step();
        drive(4'b0000, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            fill_frames('h9000 + k);
            sample_and_check();
            chk("hold_ser_val", FW'(ser_val), FW'(1'b1));
            chk("hold_ser_msg", ser_msg, exp_frame);
            advance();
        end
        ser_rdy = 1'b1;
        step();
        ser_rdy = 1'b0;
        sample_and_check();
        chk("handoff_ser_val", FW'(ser_val), FW'(1'b0));
        chk("handoff_cur_chan", FW'(cur_chan), FW'(2'd1));
        advance();

        // All channels requesting continuously: strict rotation.
        reset_dut();
        drive(4'b1111, 1'b1, 1'b1, 1'b1);
        got_idx.delete();
        for (int k = 0; k < 90; k++) begin
            sample_and_check();
            if (req_rdy != '0) got_idx.push_back(onehot_idx(req_rdy));
            advance();
        end
        for (int k = 0; k < 8; k++) begin
`ifdef SERIALIZER_ARB_FIXED_PRIO_EN
            chk($sformatf("rotation_grant%0d", k), FW'(k < got_idx.size() ? got_idx[k] : 99), FW'(0));
`else
            chk($sformatf("rotation_grant%0d", k), FW'(k < got_idx.size() ? got_idx[k] : 99), FW'(k % NCH));
`endif
        end

        // Single requester re-granted back-to-back every NS+2 cycles.
        reset_dut();
        drive(4'b0100, 1'b1, 1'b1, 1'b1);
        got_idx.delete();
        got_cyc.delete();
        for (int k = 0; k < 32; k++) begin
            sample_and_check();
            if (req_rdy != '0) begin
                got_idx.push_back(onehot_idx(req_rdy));
                got_cyc.push_back(cyc);
            end
            advance();
        end
        chk("b2b_grant_count", FW'(got_idx.size() >= 3), FW'(1'b1));
        for (int k = 0; k < 3 && k < got_idx.size(); k++) begin
            chk($sformatf("b2b_grant%0d", k), FW'(got_idx[k]), FW'(2));
            if (k > 0) chk($sformatf("b2b_gap%0d", k), FW'(got_cyc[k] - got_cyc[k-1]), FW'(NS + 2));
        end

        // Reset after three drain fires drops the frame and restores priority.
        reset_dut();
        fill_frames(0);
        drive(4'b0001, 1'b1, 1'b0, 1'b0);
        step();
        drive(4'b0000, 1'b1, 1'b0, 1'b0);
        step();
        drive(4'b0000, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) step();
        reset = 1'b1;
        drive(4'b1001, 1'b0, 1'b1, 1'b1);
        sample_and_check();
        chk("midreset_req_rdy", FW'(req_rdy), FW'(4'b0000));
        advance();
        reset = 1'b0;
        drive(4'b1001, 1'b0, 1'b0, 1'b0);
        sample_and_check();
        chk("postreset_ser_val", FW'(ser_val), FW'(1'b0));
        chk("postreset_cur_chan_val", FW'(cur_chan_val), FW'(1'b0));
        chk("postreset_grant", FW'(req_rdy), FW'(4'b0001));
        advance();

        // Randomized traffic against the model.
        for (int k = 0; k < 2000; k++) begin
            reset = ($urandom_range(63) == 0);
            for (int w = 0; w < NCH*NS; w++) req_msg[w*BW +: BW] = $urandom;
            drive(NCH'($urandom_range(15)), 1'($urandom_range(1)),
                  1'($urandom_range(1)), 1'($urandom_range(1)));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
